// File: rtl/keypad_timer_pkg.sv
// keypad_timer_pkg: shared types and limits for the keypad time-entry block
package keypad_timer_pkg;
  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t MAX_SEC_TENS = 4'd5;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_shift_buffer.sv
// bcd_shift_buffer: BCD digit shift register with entry counter, sync clear and quick-load
// Ports: clock/clearn (async active-high reset); clr_i clears buffer and count;
// quick_i loads 0:<QUICK_SECS_TENS>0 leaving count untouched; shift_i/digit_i shift a
// digit into digit 0 while not full; data_o buffer, count_o digits entered.
module bcd_shift_buffer
  import keypad_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int QUICK_SECS_TENS = 3
) (
  input  logic                    clock,
  input  logic                    clearn,
  input  logic                    clr_i,
  input  logic                    quick_i,
  input  logic                    shift_i,
  input  bcd_t                    digit_i,
  output logic [4*NUM_DIGITS-1:0] data_o,
  output logic [2:0]              count_o
);
  localparam int W = 4 * NUM_DIGITS;
  localparam logic [2:0] FULL = 3'(NUM_DIGITS);
  localparam logic [W-1:0] QUICK_BUF = W'(QUICK_SECS_TENS * 16);
  logic [W-1:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic take;
  always_comb begin
    take = shift_i && (cnt_q < FULL);
    shreg_d = clr_i ? '0 : quick_i ? QUICK_BUF : take ? {shreg_q[W-5:0], digit_i} : shreg_q;
    cnt_d = clr_i ? '0 : take ? cnt_q + 3'd1 : cnt_q;
  end
  always_ff @(posedge clock or posedge clearn)
    if (clearn) begin
      shreg_q <= '0;
      cnt_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
    end
  assign data_o = shreg_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/keypad_time_entry.sv
// keypad_time_entry: keypad BCD time entry and load/run control for a down-counter chain
// Ports: clock/clearn (async active-high reset); key_code/key_valid digit keys;
// start_key/cancel_key strobes; timer_zero from the chain; data_out/loadn parallel load;
// count_en chain enable; entry_count digits entered; error pulse on bad seconds tens.
// Define QUICK_START_EN to let start on an empty buffer load 0:<QUICK_SECS_TENS>0.
module keypad_time_entry
  import keypad_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int QUICK_SECS_TENS = 3
) (
  input  logic                    clock,
  input  logic                    clearn,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  input  logic                    start_key,
  input  logic                    cancel_key,
  input  logic                    timer_zero,
  output logic [4*NUM_DIGITS-1:0] data_out,
  output logic                    loadn,
  output logic                    count_en,
  output logic [2:0]              entry_count,
  output logic                    error
);
  state_t state_q, state_d;
  logic error_q, error_d;
  logic clr, quick, shift, key_ok;
  bcd_shift_buffer #(.NUM_DIGITS(NUM_DIGITS), .QUICK_SECS_TENS(QUICK_SECS_TENS)) u_buf (
    .clock(clock), .clearn(clearn), .clr_i(clr), .quick_i(quick), .shift_i(shift),
    .digit_i(key_code), .data_o(data_out), .count_o(entry_count)
  );
  // Priority in every state: cancel, then start, then digit key.
  always_comb begin
    state_d = state_q;
    error_d = 1'b0;
    clr = 1'b0;
    quick = 1'b0;
    shift = 1'b0;
    key_ok = key_valid && (key_code <= BCD_MAX);
    case (state_q)
      IDLE: begin
        if (cancel_key) clr = 1'b1;
`ifdef QUICK_START_EN
        else if (start_key) begin
          quick = 1'b1;
          state_d = LOAD;
        end
`else
        else if (start_key) state_d = IDLE;
`endif
        else if (key_ok) begin
          shift = 1'b1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel_key) begin
          clr = 1'b1;
          state_d = IDLE;
        end else if (start_key) begin
          error_d = data_out[7:4] > MAX_SEC_TENS;
          clr = error_d;
          state_d = error_d ? IDLE : LOAD;
        end else shift = key_ok;
      end
      LOAD: state_d = RUN;
      RUN: begin
        clr = cancel_key || timer_zero;
        state_d = clr ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge clearn)
    if (clearn) begin
      state_q <= IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  assign loadn = state_q != LOAD;
  assign count_en = state_q == RUN;
  assign error = error_q;
endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry: directed self-checking bench with a queue-based entry model
module tb_keypad_time_entry;
  localparam int ND = 3;
  localparam int P_IDLE = 0, P_ENTRY = 1, P_LOAD = 2, P_RUN = 3;
  logic clock = 1'b0;
  logic clearn = 1'b1;
  logic [3:0] key_code = '0;
  logic key_valid = 1'b0, start_key = 1'b0, cancel_key = 1'b0, timer_zero = 1'b0;
  logic [4*ND-1:0] data_out;
  logic loadn, count_en, error;
  logic [2:0] entry_count;
  int passed = 0, total = 0;
  int m_phase = P_IDLE;
  int m_dig[$];
  bit m_quick = 0, m_err = 0;
  bit run_cmp = 0;

  keypad_time_entry #(.NUM_DIGITS(ND), .QUICK_SECS_TENS(3)) dut (
    .clock(clock), .clearn(clearn), .key_code(key_code), .key_valid(key_valid),
    .start_key(start_key), .cancel_key(cancel_key), .timer_zero(timer_zero),
    .data_out(data_out), .loadn(loadn), .count_en(count_en),
    .entry_count(entry_count), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [11:0] m_data();
    int v;
    v = 0;
    if (m_quick) return 12'h030;
    foreach (m_dig[k]) v = v * 16 + m_dig[k];
    return 12'(v);
  endfunction

  task automatic m_clear();
    m_dig.delete();
    m_quick = 0;
  endtask

  // Reference behaviour: digits kept as an ordered list, oldest first.
  always @(posedge clock or posedge clearn) begin
    if (clearn) begin
      m_phase = P_IDLE;
      m_clear();
      m_err = 0;
    end else begin
      bit kok;
      int tens;
      kok = key_valid && key_code < 10;
      m_err = 0;
      if (m_phase == P_IDLE) begin
        if (cancel_key) m_clear();
        else if (start_key) begin
`ifdef QUICK_START_EN
          m_quick = 1;
          m_phase = P_LOAD;
`endif
        end else if (kok) begin
          m_dig.push_back(int'(key_code));
          m_phase = P_ENTRY;
        end
      end else if (m_phase == P_ENTRY) begin
        if (cancel_key) begin
          m_clear();
          m_phase = P_IDLE;
        end else if (start_key) begin
          tens = m_dig.size() >= 2 ? m_dig[m_dig.size() - 2] : 0;
          if (tens > 5) begin
            m_err = 1;
            m_clear();
            m_phase = P_IDLE;
          end else m_phase = P_LOAD;
        end else if (kok && m_dig.size() < ND) m_dig.push_back(int'(key_code));
      end else if (m_phase == P_LOAD) m_phase = P_RUN;
      else if (cancel_key || timer_zero) begin
        m_clear();
        m_phase = P_IDLE;
      end
    end
  end

  always @(negedge clock) if (run_cmp) begin
    chk("data_out", 32'(data_out), 32'(m_data()));
    chk("loadn", 32'(loadn), 32'(m_phase != P_LOAD));
    chk("count_en", 32'(count_en), 32'(m_phase == P_RUN));
    chk("entry_count", 32'(entry_count), 32'(m_quick ? 0 : m_dig.size()));
    chk("error", 32'(error), 32'(m_err));
  end

  task automatic tick(input logic kv, input logic [3:0] kc, input logic st, input logic cn, input logic tz);
    key_valid = kv;
    key_code = kc;
    start_key = st;
    cancel_key = cn;
    timer_zero = tz;
    @(negedge clock);
  endtask

  task automatic key(input logic [3:0] kc);
    tick(1, kc, 0, 0, 0);
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_loadn", 32'(loadn), 1);
    chk("rst_cnt_en", 32'(count_en), 0);
    clearn = 1'b0;
    run_cmp = 1;
    idle();
    key(1); key(3); key(0);
    tick(0, 0, 1, 0, 0);
    chk("t1_load_data", 32'(data_out), 32'h130);
    chk("t1_loadn", 32'(loadn), 0);
    idle();
    chk("t1_run_en", 32'(count_en), 1);
    idle();
    tick(0, 0, 0, 0, 1);
    chk("t1_zero_en", 32'(count_en), 0);
    chk("t1_zero_cnt", 32'(entry_count), 0);
    key(1); key(2); key(3); key(4);
    chk("t2_data", 32'(data_out), 32'h123);
    chk("t2_cnt", 32'(entry_count), 3);
    tick(0, 0, 0, 1, 0);
    key(7); key(5);
    tick(0, 0, 1, 0, 0);
    chk("t3_err", 32'(error), 1);
    chk("t3_data", 32'(data_out), 0);
    idle();
    chk("t3_err_end", 32'(error), 0);
    chk("t3_loadn", 32'(loadn), 1);
    tick(1, 4, 1, 0, 0);
`ifdef QUICK_START_EN
    chk("t4_quick_loadn", 32'(loadn), 0);
    chk("t4_quick_data", 32'(data_out), 32'h030);
    idle();
    tick(0, 0, 0, 0, 1);
`else
    chk("t4_key_dropped", 32'(entry_count), 0);
    tick(0, 0, 1, 0, 0);
    chk("t4_no_load", 32'(loadn), 1);
`endif
    key(0); key(5); key(9);
    tick(0, 0, 1, 0, 0);
    chk("t5_load_data", 32'(data_out), 32'h059);
    idle();
    key(8);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    chk("t5_cancel_en", 32'(count_en), 0);
    key(5);
    chk("t5_key5", 32'(data_out), 32'h005);
    tick(0, 0, 0, 1, 0);
    key(4'hA);
    chk("inv_key", 32'(entry_count), 0);
    key(0);
    tick(0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("zero_run_en", 32'(count_en), 1);
    tick(0, 0, 0, 0, 1);
    chk("zero_run_end", 32'(count_en), 0);
    key(2);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    chk("load_cancel_ignored", 32'(count_en), 1);
    tick(0, 0, 0, 0, 1);
    key(1);
    tick(0, 0, 1, 0, 0);
    chk("mid_load_loadn0", 32'(loadn), 0);
    #2 clearn = 1'b1;
    #1;
    chk("async_loadn", 32'(loadn), 1);
    chk("async_data", 32'(data_out), 0);
    chk("async_cnt", 32'(entry_count), 0);
    @(negedge clock);
    clearn = 1'b0;
    idle();
    idle();
    run_cmp = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
Upstream stage of the cooking-timer counter chain. Collects decimal key presses into a BCD time buffer (M:SS by default) and validates it on start. Drives the chain's parallel load: data bus plus a one-cycle active-low load strobe. Then holds the chain's count enable until the chain reports zero or the user cancels.

Parameters:
NUM_DIGITS, 3, number of BCD digits buffered; digit 0 = seconds ones, digit 1 = seconds tens, digit 2+ = minutes (min 2, max 4)
QUICK_SECS_TENS, 3, seconds-tens value loaded by quick start (see Optional Feature)

Ports:
clock  input  1  system clock, all state on rising edge
clearn  input  1  asynchronous reset, active-high (despite name); forces reset state immediately
key_code  input  4  BCD key value, sampled only when key_valid=1
key_valid  input  1  one-cycle strobe per debounced digit key
start_key  input  1  one-cycle strobe, start request
cancel_key  input  1  one-cycle strobe, cancel/clear request
timer_zero  input  1  high when every digit of the downstream chain reads 0
data_out  output  4*NUM_DIGITS  BCD buffer, digit i at bits [4i+3:4i], to counter data inputs
loadn  output  1  active-low synchronous load strobe to counter chain, low exactly one cycle
count_en  output  1  enable to least-significant counter of the chain
entry_count  output  3  number of digits entered, 0..NUM_DIGITS
error  output  1  one-cycle pulse, start rejected (seconds tens > 5)

Behaviour:
- Reset (clearn=1, async): state IDLE; buffer all 0; entry_count=0; loadn=1; count_en=0; error=0.
- States: IDLE, ENTRY, LOAD, RUN.
- IDLE:
  - Valid key (key_valid=1, key_code<=9) -> buffer shifts up one digit; new digit enters digit 0; top digit discarded. entry_count=1; go ENTRY.
- ENTRY:
  - Valid key with entry_count<NUM_DIGITS -> shift in as above; entry_count+1.
  - Valid key at entry_count==NUM_DIGITS -> ignored; buffer unchanged.
- Invalid codes: key_code 10..15 ignored in all states.
- start_key in ENTRY:
  - If digit 1 > 5 -> error pulses 1 cycle; buffer and entry_count cleared; go IDLE.
  - Else go LOAD.
- start_key in IDLE (empty buffer): ignored unless QUICK_START_EN is defined.
- LOAD: loadn=0 for this single cycle; data_out stable = buffer; count_en=0; next state RUN unconditionally.
- RUN:
  - count_en=1; key_valid and start_key ignored.
  - timer_zero sampled from the first RUN cycle onward (chain has loaded by then). timer_zero=1 -> count_en=0 next cycle; buffer cleared; entry_count=0; go IDLE.
  - An entered 0:00 therefore runs for exactly one RUN cycle.
- cancel_key:
  - In ENTRY or IDLE -> clear buffer and entry_count; go IDLE.
  - In RUN -> count_en=0 next cycle; go IDLE; chain holds its value.
  - In LOAD -> ignored; load completes.
- Simultaneous events:
  - cancel_key beats start_key beats key_valid; the lower-priority strobes are dropped.
  - clearn mid-LOAD -> loadn returns to 1 immediately.
- data_out always reflects the buffer; it is meaningful to the chain only while loadn=0.

Optional Feature:
QUICK_START_EN
- Defined: start_key in IDLE with empty buffer loads 0:QUICK_STARTS_TENS 0 (default 0:30). Goes straight to LOAD, no validation; entry_count stays 0.
- Not defined: start_key in IDLE is ignored, no state change and no error.

Decomposition:
- Package keypad_timer_pkg: state enum (IDLE/ENTRY/LOAD/RUN), 4-bit bcd_t typedef, MAX_SEC_TENS=5, BCD_MAX=9.
- Sub-module bcd_shift_buffer (parameter NUM_DIGITS): owns the digit shift register, entry counter, synchronous clear and quick-load inputs. The FSM stays in the top.

Test Plan:
- Reset, then keys 1,3,0, start -> loadn low 1 cycle with data_out=0x130, count_en=1 from next cycle; timer_zero=1 -> count_en=0 next cycle, entry_count=0.
- Keys 1,2,3,4 (NUM_DIGITS=3) -> buffer 0x123, entry_count=3; fourth key ignored.
- Keys 7,5, start -> error pulse 1 cycle, loadn stays 1, buffer 0x000, state IDLE.
- Key 4 with start_key same cycle, then start in IDLE -> key dropped; no loadn without QUICK_START_EN, loadn with 0x030 with it.
- Running with 0x059 loaded, cancel_key -> count_en=0 next cycle; key 5 then accepted into an empty buffer (0x005).
- clearn asserted mid-LOAD -> loadn=1 and all outputs at reset values immediately, without a clock edge.
